timebin_run_sequencer: RTL
==========================

# timebin_run_sequencer

Run controller for the PMT timebin counting path. It starts and stops acquisition runs from the front-panel buttons and generates the timebin boundaries. At each boundary it clears the external photon counter and captures its count, then serialises each captured count as two bytes into the UART transmitter over a valid/ready handshake. It sits between the PMT pulse counter and the UART module.

## Interface
- `CYCLES_PER_UNIT`, 5000: clk cycles per timebin unit (100 us at 50 MHz).
- `TICK_W`, 21: tick counter width; must hold 255*CYCLES_PER_UNIT.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_button` in 1: raw pushbutton, active-low.
- `stop_button` in 1: raw pushbutton, active-low.
- `timebin_factor` in 8: bin length in units; sampled at run start.
- `num_bins` in 16: bins per run; 0 = continuous until stop; sampled at run start.
- `count_in` in 16: current photon count from the PMT counter.
- `counter_clear` out 1: one-cycle pulse that clears the PMT counter.
- `tx_data` out 8: byte to the UART.
- `tx_valid` out 1: tx_data valid.
- `tx_ready` in 1: UART accepts the byte on a clk edge where tx_valid && tx_ready.
- `running` out 1: high in RUN.
- `led` out 1: toggles at every run start.
- `run_done` out 1: one-cycle pulse on return to IDLE.
- `overrun` out 1: sticky; set when a bin is dropped, cleared at run start.
- `overrun_cnt` out 8: dropped bins this run, saturates at 255, cleared at run start.

## Operation
- Buttons pass through a 2-flop synchroniser. A start or stop event is a falling edge of the synchronised signal.
- States: IDLE, RUN, DRAIN.
  - IDLE: on start event, latch `timebin_factor` and `num_bins`, clear overrun state, toggle `led`, pulse `counter_clear`, zero the tick counter, go to RUN.
  - RUN: tick counter increments every cycle. When tick == factor*CYCLES_PER_UNIT−1:
    - tick counter returns to 0;
    - `count_in` is captured;
    - `counter_clear` pulses;
    - bin counter increments.
  - RUN exit: when bin counter reaches the latched `num_bins` (nonzero), go to DRAIN after that bin's capture.
  - DRAIN: wait until the TX holding register is empty, then pulse `run_done` and go to IDLE.
- A latched factor of 0 is treated as 1.
- Stop event in RUN goes to DRAIN immediately. The partial bin is discarded and the pending capture is still sent.
- Start events in RUN or DRAIN are ignored. Stop events in IDLE or DRAIN are ignored.
- TX holding register: one 16-bit word plus a byte pointer. The MSB byte is sent first, then the LSB. The register becomes empty on the handshake of the LSB.
- If a capture occurs while the register is non-empty, the new count is dropped, `overrun` is set and `overrun_cnt` increments. The in-flight word is never corrupted.
- Multiplication `factor*CYCLES_PER_UNIT` is computed once at run start into a TICK_W register.

## Timing
- Reset values:
  - outputs: `counter_clear`=0, `tx_valid`=0, `tx_data`=0, `running`=0, `led`=0, `run_done`=0, `overrun`=0, `overrun_cnt`=0;
  - state IDLE, all counters 0.
- Start latency: a button falling edge at the pin reaches RUN 3 cycles later. `counter_clear` is asserted in the first RUN cycle.
- Bin period: exactly factor*CYCLES_PER_UNIT cycles between successive `counter_clear` pulses.
- Capture to TX: `tx_valid` rises in the cycle after capture with the MSB byte. `tx_data`/`tx_valid` stay stable until handshake. The LSB byte is presented in the cycle after the MSB handshake.
- `tx_valid` never depends combinationally on `tx_ready`.
- A capture in the same cycle as the LSB handshake is accepted, not an overrun.
- Reset mid-run: all state aborts asynchronously. `tx_valid` drops immediately and no partial word resumes.

## Configuration
- `SEQ_HEADER_EN` defined: on each run start, the word {8'hA5, latched factor} is loaded into the TX holding register before any bin, so the host sees 0xA5 then the factor. The first bin capture is never an overrun if the header handshakes within one bin period.
- `SEQ_HEADER_EN` undefined: no header; TX carries bin data only.

## Test plan
- CYCLES_PER_UNIT=10, factor=3, num_bins=4, `tx_ready` tied 1, `count_in` ramps → `counter_clear` pulses 30 cycles apart, 8 bytes out MSB-first matching captured counts, `run_done` once, `running` falls.
- factor=0, num_bins=2 → period 10 cycles, 2 bins sent.
- `tx_ready` held 0 for 70 cycles at factor=3 → first word intact, 2 bins dropped, `overrun`=1, `overrun_cnt`=2.
- num_bins=0, stop pressed mid-bin 5 → 4 words sent, no 5th, `run_done` after drain; a start event pressed during RUN has no effect.
- `reset_n` pulsed low while `tx_valid`=1 → all outputs at reset values immediately; next start runs normally.
- With `SEQ_HEADER_EN`, factor=7 → first bytes 0xA5, 0x07, then bin data.

Source files
------------

// File: rtl/timebin_run_sequencer.sv
// Purpose : run controller for the PMT timebin path; button start/stop, timebin boundaries,
//           counter clear/capture, and two-byte (MSB first) serialisation of each count to the UART.
// Latency : start/stop pin edge -> state change 3 cycles; capture -> tx_valid next cycle.
// Backpr. : one-word TX holding register; captures arriving while it is busy are dropped
//           and counted as overruns; tx_valid never depends combinationally on tx_ready.
//
// Ports   : clk/reset_n (async active-low); start_button/stop_button (raw, active-low);
//           timebin_factor/num_bins (sampled at run start); count_in (PMT count);
//           counter_clear (1-cycle pulse); tx_data/tx_valid/tx_ready (byte handshake);
//           running, led, run_done, overrun, overrun_cnt (status).
// Option  : define SEQ_HEADER_EN to send {8'hA5, factor} at each run start.

module timebin_run_sequencer #(
    parameter int CYCLES_PER_UNIT = 5000,
    parameter int TICK_W          = 21
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_button,
    input  logic        stop_button,
    input  logic [7:0]  timebin_factor,
    input  logic [15:0] num_bins,
    input  logic [15:0] count_in,
    output logic        counter_clear,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        running,
    output logic        led,
    output logic        run_done,
    output logic        overrun,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;

    // [0],[1] = synchroniser stages, [2] = previous synchronised value for edge detect
    logic [2:0]          r_start_sync;
    logic [2:0]          r_stop_sync;

    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   r_period_m1;
    logic [15:0]         r_bin;
    logic [15:0]         r_nbins;

    logic                r_counter_clear;
    logic                r_running;
    logic                r_led;
    logic                r_run_done;
    logic                r_overrun;
    logic [7:0]          r_overrun_cnt;

    // TX holding register: tx_data holds the byte on the wire, r_tx_lsb the byte still to go
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic [7:0]          r_tx_lsb;
    logic                r_lsb_phase;

    logic                w_start_evt;
    logic                w_stop_evt;
    logic [7:0]          w_factor_eff;
    logic [TICK_W-1:0]   w_period;
    logic                w_boundary;
    logic [15:0]         w_bin_next;
    logic                w_last_bin;
    logic                w_hs;
    logic                w_hold_free;

    assign w_start_evt  = r_start_sync[2] & ~r_start_sync[1];
    assign w_stop_evt   = r_stop_sync[2]  & ~r_stop_sync[1];

    assign w_factor_eff = (timebin_factor == 8'd0) ? 8'd1 : timebin_factor;
    assign w_period     = TICK_W'(w_factor_eff) * TICK_W'(CYCLES_PER_UNIT);

    assign w_boundary   = (r_state == ST_RUN) && (r_tick == r_period_m1);
    assign w_bin_next   = r_bin + 16'd1;
    assign w_last_bin   = (r_nbins != 16'd0) && (w_bin_next == r_nbins);

    assign w_hs         = r_tx_valid && tx_ready;
    // A capture coinciding with the LSB handshake may reuse the register in the same edge
    assign w_hold_free  = !r_tx_valid || (w_hs && r_lsb_phase);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_start_sync    <= 3'b111;
            r_stop_sync     <= 3'b111;
            r_tick          <= '0;
            r_period_m1     <= '0;
            r_bin           <= '0;
            r_nbins         <= '0;
            r_counter_clear <= 1'b0;
            r_running       <= 1'b0;
            r_led           <= 1'b0;
            r_run_done      <= 1'b0;
            r_overrun       <= 1'b0;
            r_overrun_cnt   <= '0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= '0;
            r_tx_lsb        <= '0;
            r_lsb_phase     <= 1'b0;
        end else begin
            r_start_sync    <= {r_start_sync[1:0], start_button};
            r_stop_sync     <= {r_stop_sync[1:0], stop_button};
            r_counter_clear <= 1'b0;
            r_run_done      <= 1'b0;

            // Byte pointer advance; a load further down overrides these
            if (w_hs) begin
                if (!r_lsb_phase) begin
                    r_tx_data   <= r_tx_lsb;
                    r_lsb_phase <= 1'b1;
                end else begin
                    r_tx_valid  <= 1'b0;
                    r_lsb_phase <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_evt) begin
                        r_period_m1     <= w_period - TICK_W'(1);
                        r_nbins         <= num_bins;
                        r_overrun       <= 1'b0;
                        r_overrun_cnt   <= '0;
                        r_led           <= ~r_led;
                        r_counter_clear <= 1'b1;
                        r_tick          <= '0;
                        r_bin           <= '0;
                        r_running       <= 1'b1;
                        r_state         <= ST_RUN;
`ifdef SEQ_HEADER_EN
                        // Register is always empty in IDLE, so the header load is unconditional
                        r_tx_valid      <= 1'b1;
                        r_tx_data       <= 8'hA5;
                        r_tx_lsb        <= timebin_factor;
                        r_lsb_phase     <= 1'b0;
`endif
                    end
                end

                ST_RUN: begin
                    if (w_stop_evt) begin
                        // Partial bin is abandoned; whatever is in the holding register still drains
                        r_running <= 1'b0;
                        r_state   <= ST_DRAIN;
                    end else if (w_boundary) begin
                        r_tick          <= '0;
                        r_counter_clear <= 1'b1;
                        r_bin           <= w_bin_next;
                        if (w_hold_free) begin
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= count_in[15:8];
                            r_tx_lsb    <= count_in[7:0];
                            r_lsb_phase <= 1'b0;
                        end else begin
                            r_overrun <= 1'b1;
                            if (r_overrun_cnt != 8'hFF) begin
                                r_overrun_cnt <= r_overrun_cnt + 8'd1;
                            end
                        end
                        if (w_last_bin) begin
                            r_running <= 1'b0;
                            r_state   <= ST_DRAIN;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (!r_tx_valid) begin
                        r_run_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign counter_clear = r_counter_clear;
    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign running       = r_running;
    assign led           = r_led;
    assign run_done      = r_run_done;
    assign overrun       = r_overrun;
    assign overrun_cnt   = r_overrun_cnt;

endmodule
